register_write_arbiter: RTL and testbench

REGISTER_WRITE_ARBITER -- requirements
Module: register_write_arbiter

---
 rtl/register_write_arbiter.sv | 126 ++++++++++++
 tb/tb_register_write_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/register_write_arbiter.sv
// Arbiter for a shared register write port: IDLE/OWN FSM, hold-limited ownership, one-cycle turnaround.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; the default build uses fixed priority (0 highest).
module register_write_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] request,
    output logic [3:0] grant,
    output logic [1:0] grant_index,
    output logic       grant_enable,
    output logic       busy,
    output logic       timeout_flag
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       owner;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       winner_c;
    logic             rel_vol_c;
    logic             rel_forced_c;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr;

    // First requester at or above the pointer, wrapping around
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner_c = ptr;
        found    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && request[idx]) begin
                winner_c = idx;
                found    = 1'b1;
            end
        end
    end
`else
    // Lowest requesting index wins
    always_comb begin
        winner_c = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (request[k]) begin
                winner_c = 2'(k);
            end
        end
    end
`endif

    assign rel_vol_c    = !request[owner];
    assign rel_forced_c = (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= 2'd0;
            hold_cnt     <= '0;
            grant        <= 4'b0000;
            grant_index  <= 2'd0;
            grant_enable <= 1'b0;
            busy         <= 1'b0;
            timeout_flag <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr          <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    timeout_flag <= 1'b0;
                    if (request != 4'b0000) begin
                        state        <= OWN;
                        owner        <= winner_c;
                        hold_cnt     <= '0;
                        grant        <= 4'b0001 << winner_c;
                        grant_index  <= winner_c;
                        grant_enable <= 1'b1;
                        busy         <= 1'b1;
                    end else begin
                        grant        <= 4'b0000;
                        grant_index  <= 2'd0;
                        grant_enable <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                OWN: begin
                    if (rel_vol_c || rel_forced_c) begin
                        // Voluntary release takes precedence over timeout when both occur
                        state        <= IDLE;
                        hold_cnt     <= '0;
                        grant        <= 4'b0000;
                        grant_index  <= 2'd0;
                        grant_enable <= 1'b0;
                        busy         <= 1'b0;
                        timeout_flag <= rel_forced_c && !rel_vol_c;
`ifdef ARB_ROUND_ROBIN_EN
                        ptr          <= owner + 2'd1;
`endif
                    end else begin
                        hold_cnt     <= hold_cnt + CNT_W'(1);
                        timeout_flag <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    hold_cnt     <= '0;
                    grant        <= 4'b0000;
                    grant_index  <= 2'd0;
                    grant_enable <= 1'b0;
                    busy         <= 1'b0;
                    timeout_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter (MAX_HOLD=4); outputs sampled 1 time unit after each rising edge.
module tb_register_write_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] request;
    logic [3:0] grant;
    logic [1:0] grant_index;
    logic       grant_enable;
    logic       busy;
    logic       timeout_flag;

    int compared   = 0;
    int mismatched = 0;

    register_write_arbiter #(.MAX_HOLD(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .request      (request),
        .grant        (grant),
        .grant_index  (grant_index),
        .grant_enable (grant_enable),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    // Packed view: {grant, grant_index, grant_enable, busy, timeout_flag}
    function automatic logic [8:0] owned(input logic [1:0] idx);
        logic [3:0] g;
        g = 4'b0001 << idx;
        return {g, idx, 1'b1, 1'b1, 1'b0};
    endfunction

    function automatic logic [8:0] idle(input logic tf);
        return {4'b0000, 2'd0, 1'b0, 1'b0, tf};
    endfunction

    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {grant, grant_index, grant_enable, busy, timeout_flag};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed g=%b idx=%0d en=%b busy=%b tf=%b expected g=%b idx=%0d en=%b busy=%b tf=%b",
                   tag, obs[8:5], obs[4:3], obs[2], obs[1], obs[0],
                   exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        request = 4'b0000;
        #1;
        check("reset_state", idle(1'b0));
        step();
        step();
        rst = 1'b0;
        step();
        check("idle_no_request", idle(1'b0));

        // Held single request: 4 owned cycles, timeout IDLE, re-grant
        request = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("hold_r2_c%0d", c), owned(2'd2));
        end
        step();
        check("timeout_idle", idle(1'b1));
        step();
        check("regrant_r2", owned(2'd2));

        // Non-owner requests must not disturb the current owner
        request = 4'b0111;
        step();
        check("nonowner_change", owned(2'd2));
        request = 4'b0000;
        step();
        check("vol_release_idle", idle(1'b0));
        step();
        check("stay_idle", idle(1'b0));

        // Two-cycle voluntary release
        request = 4'b0010;
        step();
        check("r1_c0", owned(2'd1));
        step();
        check("r1_c1", owned(2'd1));
        request = 4'b0000;
        step();
        check("r1_vol_no_timeout", idle(1'b0));

        // Drop request exactly at the last hold cycle: counts as voluntary
        request = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("r0_c%0d", c), owned(2'd0));
        end
        request = 4'b0000;
        step();
        check("coincide_no_timeout", idle(1'b0));

        // All requesting: priority order depends on the build
        request = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("all_first_c%0d", c), owned(2'd0));
        end
        step();
        check("all_timeout", idle(1'b1));
        step();
`ifdef ARB_ROUND_ROBIN_EN
        check("all_second_owner", owned(2'd1));
`else
        check("all_second_owner", owned(2'd0));
`endif
        request = 4'b0000;
        step();
        check("all_release", idle(1'b0));

        // Asynchronous reset while requester 3 owns the port
        request = 4'b1000;
        step();
        check("r3_granted", owned(2'd3));
        #2 rst = 1'b1;
        #1;
        check("async_reset_drop", idle(1'b0));
        #1 rst = 1'b0;
        step();
        check("r3_after_reset", owned(2'd3));

        // Pointer restarts at 0 after reset
        #2 rst = 1'b1;
        request = 4'b1111;
        #1 rst = 1'b0;
        step();
        check("ptr_restart", owned(2'd0));

        request = 4'b0000;
        step();
        step();
        check("final_idle", idle(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
